// File: rtl/sysmgr_pkg.sv
// Shared types and helpers for the system-manager reset sequencer.
package sysmgr_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  typedef struct packed {
    logic qual_lock;
    logic qual_loss;
  } lock_evt_t;

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sysmgr_lock_filt.sv
// PLL lock synchroniser plus consecutive-sample qualifier; emits single-cycle
// qualified lock / qualified loss pulses on the edge taking the final sample.
module sysmgr_lock_filt
  import sysmgr_pkg::*;
#(
  parameter int LOCK_FILT = 4
) (
  input  logic      clk_in,
  input  logic      clr,
  input  logic      pll_lock,
  output lock_evt_t evt
);

  localparam int FW = cnt_w(LOCK_FILT + 1);

  logic [1:0]    sync;
  logic          lock_s;
  logic [FW-1:0] hi_cnt;
  logic [FW-1:0] lo_cnt;

  assign lock_s = sync[1];

  always_ff @(posedge clk_in) begin
    if (clr) sync <= '0;
    else     sync <= {sync[0], pll_lock};
  end

  // Run-length counters saturate at LOCK_FILT so each run pulses only once.
  always_ff @(posedge clk_in) begin
    if (clr) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else if (lock_s) begin
      lo_cnt <= '0;
      if (hi_cnt != FW'(LOCK_FILT)) hi_cnt <= hi_cnt + 1'b1;
    end else begin
      hi_cnt <= '0;
      if (lo_cnt != FW'(LOCK_FILT)) lo_cnt <= lo_cnt + 1'b1;
    end
  end

  assign evt.qual_lock = lock_s  && (hi_cnt == FW'(LOCK_FILT - 1));
  assign evt.qual_loss = !lock_s && (lo_cnt == FW'(LOCK_FILT - 1));

endmodule

// File: rtl/sysmgr_rst_seq.sv
// Multi-domain reset sequencer: PLL reset, lock qualify, stretch, staggered release.
// Build option RESET_SEQ_RETRY_EN adds a WAIT_LOCK timeout that re-pulses pll_rst.
module sysmgr_rst_seq
  import sysmgr_pkg::*;
#(
  parameter int N_DOMAINS      = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILT      = 4,
  parameter int STRETCH_CYCLES = 128,
  parameter int STAGE_DELAY    = 16,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic [N_DOMAINS-1:0]  rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CW = cnt_w(max_int(PLL_RST_CYCLES, max_int(STRETCH_CYCLES, STAGE_DELAY)));

  state_e                state;
  logic [CW-1:0]         cnt;
  logic [N_DOMAINS-1:0]  rst_q;
  logic [N_DOMAINS-1:0]  rel_nxt;
  logic                  ready_q;
  logic [LOSS_CNT_W-1:0] lcnt;
  logic                  stage_done;
  logic                  timeout;
  lock_evt_t             evt;

  // Sync chain is held clear during PLL reset so lock is re-qualified from scratch.
  sysmgr_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_filt (
    .clk_in   (clk_in),
    .clr      (rst_in || (state == ST_PLL_RST)),
    .pll_lock (pll_lock),
    .evt      (evt)
  );

`ifdef RESET_SEQ_RETRY_EN
  localparam int     TW          = cnt_w(LOCK_TIMEOUT);
  localparam state_e RUN_LOSS_ST = ST_PLL_RST;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || (state != ST_WAIT_LOCK)) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == ST_WAIT_LOCK) && (to_cnt == TW'(LOCK_TIMEOUT - 1));
`else
  localparam state_e RUN_LOSS_ST = ST_WAIT_LOCK;
  logic unused_timeout;
  assign unused_timeout = (LOCK_TIMEOUT > 0);
  assign timeout        = 1'b0;
`endif

  assign rel_nxt    = rst_q << 1;
  assign stage_done = ((state == ST_STRETCH) && (cnt == CW'(STRETCH_CYCLES - 1))) ||
                      ((state == ST_RELEASE) && (cnt == CW'(STAGE_DELAY - 1)));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= ST_PLL_RST;
      cnt     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      lcnt    <= '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          cnt <= '0;
          if (evt.qual_lock)  state <= ST_STRETCH;
          else if (timeout)   state <= ST_PLL_RST;
        end
        ST_STRETCH, ST_RELEASE: begin
          // Loss wins over a release that falls on the same edge.
          if (evt.qual_loss) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
          end else if (stage_done) begin
            cnt   <= '0;
            rst_q <= rel_nxt;
            if (rel_nxt == '0) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (evt.qual_loss) begin
            state   <= RUN_LOSS_ST;
            cnt     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            if (lcnt != {LOSS_CNT_W{1'b1}}) lcnt <= lcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_PLL_RST;
          cnt   <= '0;
          rst_q <= '1;
        end
      endcase
    end
  end

  assign pll_rst       = (state == ST_PLL_RST);
  assign rst_out       = rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lcnt;

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Directed bench for sysmgr_rst_seq: event scoreboard on the default instance,
// point checks on a 4-domain instance and a 1-domain timeout instance.
module tb_sysmgr_rst_seq;

`ifdef RESET_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  logic       rst_a, lock_a, pll_a, rdy_a;
  logic [1:0] ro_a;
  logic [7:0] lc_a;
  logic       rst_b, lock_b, pll_b, rdy_b;
  logic [3:0] ro_b;
  logic [7:0] lc_b;
  logic       rst_c, lock_c, pll_c, rdy_c;
  logic [0:0] ro_c;
  logic [7:0] lc_c;

  sysmgr_rst_seq dut_a (
    .clk_in(clk), .rst_in(rst_a), .pll_lock(lock_a), .pll_rst(pll_a),
    .rst_out(ro_a), .ready(rdy_a), .lock_loss_cnt(lc_a)
  );

  sysmgr_rst_seq #(
    .N_DOMAINS(4), .PLL_RST_CYCLES(4), .LOCK_FILT(2), .STRETCH_CYCLES(8), .STAGE_DELAY(8)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .pll_lock(lock_b), .pll_rst(pll_b),
    .rst_out(ro_b), .ready(rdy_b), .lock_loss_cnt(lc_b)
  );

  sysmgr_rst_seq #(.N_DOMAINS(1), .LOCK_TIMEOUT(100)) dut_c (
    .clk_in(clk), .rst_in(rst_c), .pll_lock(lock_c), .pll_rst(pll_c),
    .rst_out(ro_c), .ready(rdy_c), .lock_loss_cnt(lc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: cycle of change and {pll_rst, rst_out, ready, lock_loss_cnt}.
  typedef struct packed {
    int          c;
    logic [11:0] v;
  } ev_t;

  ev_t         q[$];
  logic [11:0] prev_v;
  logic [11:0] cur_v;
  bit          mon_en = 1'b0;

  function automatic void push(input int c, input logic p, input logic [1:0] ro,
                               input logic rdy, input logic [7:0] lc);
    ev_t e;
    e.c = c;
    e.v = {p, ro, rdy, lc};
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    cur_v = {pll_a, ro_a, rdy_a, lc_a};
    if (mon_en && (cur_v !== prev_v)) begin
      if (q.size() == 0) begin
        chk("a_unexpected_change", {20'd0, cur_v}, {20'd0, prev_v});
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("a_ev_cycle", cyc, e.c);
        chk("a_ev_value", {20'd0, cur_v}, {20'd0, e.v});
      end
    end
    prev_v = cur_v;
  end

  task automatic wait_q(input int budget, input string tag);
    for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t0, d, r, r2, lt;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    lock_a = 1'b1; lock_b = 1'b1; lock_c = 1'b0;
    repeat (5) @(negedge clk);

    chk("a_rst_pll", pll_a, 1);
    chk("a_rst_out", ro_a, 2'b11);
    chk("a_rst_ready", rdy_a, 0);
    chk("a_rst_cnt", lc_a, 0);
    chk("b_rst_out", ro_b, 4'hf);
    chk("c_rst_pll", pll_c, 1);

    // Cold release with lock steady: 16 / 150 / 166
    t0 = cyc;
    push(t0 + 16,  1'b0, 2'b11, 1'b0, 8'd0);
    push(t0 + 150, 1'b0, 2'b10, 1'b0, 8'd0);
    push(t0 + 166, 1'b0, 2'b00, 1'b1, 8'd0);
    mon_en = 1'b1;
    rst_a  = 1'b0;
    wait_q(220, "a_first_release");
    repeat (5) @(negedge clk);

    // Three-cycle lock glitch is filtered out
    lock_a = 1'b0;
    repeat (3) @(negedge clk);
    lock_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("a_glitch_ready", rdy_a, 1);
    chk("a_glitch_cnt", lc_a, 0);

    // Real loss in RUN, lock returns 26 cycles after it dropped
    d = cyc;
    push(d + 6, RETRY, 2'b11, 1'b0, 8'd1);
    if (RETRY) push(d + 22, 1'b0, 2'b11, 1'b0, 8'd1);
    push(d + 26 + 134, 1'b0, 2'b10, 1'b0, 8'd1);
    push(d + 26 + 150, 1'b0, 2'b00, 1'b1, 8'd1);
    lock_a = 1'b0;
    wait_to(d + 26);
    lock_a = 1'b1;
    wait_q(300, "a_relock");
    repeat (5) @(negedge clk);

    // rst_in pulse from RUN, then a second pulse in the middle of STRETCH
    r = cyc;
    push(r + 1,  1'b1, 2'b11, 1'b0, 8'd0);
    push(r + 17, 1'b0, 2'b11, 1'b0, 8'd0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wait_to(r + 80);
    r2 = cyc;
    push(r2 + 1, 1'b1, 2'b11, 1'b0, 8'd0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    push(r2 + 17,  1'b0, 2'b11, 1'b0, 8'd0);
    push(r2 + 151, 1'b0, 2'b10, 1'b0, 8'd0);
    push(r2 + 167, 1'b0, 2'b00, 1'b1, 8'd0);
    wait_q(300, "a_restart");

    // 4-domain staggered release: 4+2+2+8+3*8 = 40
    t0 = cyc;
    rst_b = 1'b0;
    wait_to(t0 + 15); chk("b_pre_rel0", ro_b, 4'hf);
    wait_to(t0 + 16); chk("b_rel0", ro_b, 4'he);
    wait_to(t0 + 24); chk("b_rel1", ro_b, 4'hc);
    wait_to(t0 + 39); chk("b_pre_last", ro_b, 4'h8);
    chk("b_pre_last_rdy", rdy_b, 0);
    wait_to(t0 + 40); chk("b_last", ro_b, 4'h0);
    chk("b_last_rdy", rdy_b, 1);

    // Loss during RELEASE after bit 1 released
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    t0 = cyc;
    wait_to(t0 + 24); chk("b2_rel1", ro_b, 4'hc);
    lock_b = 1'b0;
    wait_to(t0 + 27); chk("b2_pre_loss", ro_b, 4'hc);
    wait_to(t0 + 28); chk("b2_loss_out", ro_b, 4'hf);
    chk("b2_loss_rdy", rdy_b, 0);
    chk("b2_loss_cnt", lc_b, 0);
    lock_b = 1'b1;

    // Loss qualified on the same edge as the bit-2 release
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    t0 = cyc;
    wait_to(t0 + 28);
    lock_b = 1'b0;
    wait_to(t0 + 31); chk("b3_pre", ro_b, 4'hc);
    wait_to(t0 + 32); chk("b3_loss_wins", ro_b, 4'hf);
    lock_b = 1'b1;

    // Loss counter saturation
    for (int k = 0; k < 200 && !rdy_b; k++) @(negedge clk);
    chk("b4_ready", rdy_b, 1);
    for (int i = 0; i < 256; i++) begin
      lock_b = 1'b0;
      for (int k = 0; k < 50 && rdy_b; k++) @(negedge clk);
      lock_b = 1'b1;
      for (int k = 0; k < 200 && !rdy_b; k++) @(negedge clk);
      if (!rdy_b) begin
        chk("b4_relock", rdy_b, 1);
        break;
      end
      if (i == 0)   chk("b4_cnt1", lc_b, 1);
      if (i == 254) chk("b4_cnt255", lc_b, 255);
    end
    chk("b4_sat", lc_b, 255);

    // Lock held low: pll_rst re-pulses only with the retry build
    t0 = cyc;
    rst_c = 1'b0;
    wait_to(t0 + 15);  chk("c_pll_hold", pll_c, 1);
    wait_to(t0 + 16);  chk("c_pll_fall", pll_c, 0);
    wait_to(t0 + 115); chk("c_pre_to", pll_c, 0);
    wait_to(t0 + 116); chk("c_to1_rise", pll_c, RETRY);
    wait_to(t0 + 131); chk("c_to1_hold", pll_c, RETRY);
    wait_to(t0 + 132); chk("c_to1_fall", pll_c, 0);
    wait_to(t0 + 231); chk("c_pre_to2", pll_c, 0);
    wait_to(t0 + 232); chk("c_to2_rise", pll_c, RETRY);

    // Single-domain release: zero-length RELEASE, ready with bit 0
    wait_to(t0 + 260);
    lt = cyc;
    lock_c = 1'b1;
    wait_to(lt + 133); chk("c_pre_rel", ro_c, 1);
    chk("c_pre_rdy", rdy_c, 0);
    wait_to(lt + 134); chk("c_rel", ro_c, 0);
    chk("c_rdy", rdy_c, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
